// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect, and decode handshake.
// The master modport is the fetch unit's view; the slave modport is the memory/decode side.
interface fetch_unit_if #(
  parameter int Xlen = 32,
  parameter int Ilen = 32
);
  logic            instmem_ready_i;
  logic            instmem_valid_o;
  logic [Xlen-1:0] instmem_addr_o;
  logic [Ilen-1:0] instmem_rdata_i;
  logic            instmem_rvalid_i;
  logic            redirect_valid_i;
  logic [Xlen-1:0] redirect_pc_i;
  logic            inst_valid_o;
  logic [Xlen-1:0] inst_pc_o;
  logic [Ilen-1:0] inst_data_o;
  logic            inst_ready_i;

  modport master (
    input  instmem_ready_i, instmem_rdata_i, instmem_rvalid_i,
    input  redirect_valid_i, redirect_pc_i, inst_ready_i,
    output instmem_valid_o, instmem_addr_o,
    output inst_valid_o, inst_pc_o, inst_data_o
  );

  modport slave (
    output instmem_ready_i, instmem_rdata_i, instmem_rvalid_i,
    output redirect_valid_i, redirect_pc_i, inst_ready_i,
    input  instmem_valid_o, instmem_addr_o,
    input  inst_valid_o, inst_pc_o, inst_data_o
  );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch with bounded outstanding requests, response FIFO and redirect flush.
// Define FETCH_UNIT_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter int              Xlen           = 32,
  parameter int              Ilen           = 32,
  parameter int              DepthLog2      = 2,
  parameter int              MaxOutstanding = 2,
  parameter logic [Xlen-1:0] ResetPc        = '0
) (
  input logic          clk_i,
  input logic          rst_ni,
  fetch_unit_if.master bus
);
  localparam int              Depth = 2 ** DepthLog2;
  localparam int              IfW   = $clog2(MaxOutstanding + 1);
  localparam int              CntW  = DepthLog2 + 1;
  localparam logic [IfW-1:0]  MaxOs = IfW'(MaxOutstanding);

  logic [Xlen-1:0]      req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
  logic [IfW-1:0]       inflight_q, inflight_d, drop_q, drop_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Xlen-1:0]      pc_mem_q   [Depth];
  logic [Ilen-1:0]      inst_mem_q [Depth];

  logic            redir, room_ok, issue, req_fire, rsp_fire, keep, byp, push, pop;
  logic [Xlen-1:0] redir_pc;
  logic [IfW-1:0]  live;

  assign redir    = bus.redirect_valid_i;
  assign redir_pc = {bus.redirect_pc_i[Xlen-1:1], 1'b0};
  assign live     = inflight_q - drop_q;
  // Every live in-flight request owns a FIFO slot, so a kept response always has room.
  assign room_ok  = (32'(count_q) + 32'(live)) < 32'(Depth);
  assign issue    = rst_ni && (inflight_q < MaxOs) && (redir || room_ok);
  assign req_fire = issue && bus.instmem_ready_i;
  assign rsp_fire = bus.instmem_rvalid_i && (inflight_q != '0);
  assign keep     = rsp_fire && !redir && (drop_q == '0);

`ifdef FETCH_UNIT_BYPASS_EN
  assign byp = keep && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign push = keep && !(byp && bus.inst_ready_i);
  assign pop  = (count_q != '0) && bus.inst_ready_i && !redir;

  assign bus.instmem_valid_o = issue;
  assign bus.instmem_addr_o  = redir ? redir_pc : req_pc_q;

`ifdef FETCH_UNIT_BYPASS_EN
  assign bus.inst_valid_o = (count_q != '0) || byp;
  assign bus.inst_pc_o    = (count_q != '0) ? pc_mem_q[rd_ptr_q]   : rsp_pc_q;
  assign bus.inst_data_o  = (count_q != '0) ? inst_mem_q[rd_ptr_q] : bus.instmem_rdata_i;
`else
  assign bus.inst_valid_o = (count_q != '0);
  assign bus.inst_pc_o    = pc_mem_q[rd_ptr_q];
  assign bus.inst_data_o  = inst_mem_q[rd_ptr_q];
`endif

  always_comb begin
    req_pc_d   = req_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + IfW'(req_fire) - IfW'(rsp_fire);
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redir) begin
      // Everything still outstanding (minus this cycle's response) becomes stale.
      drop_d   = inflight_q - IfW'(rsp_fire);
      rsp_pc_d = redir_pc;
      req_pc_d = req_fire ? redir_pc + Xlen'(4) : redir_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - IfW'(1);
      if (keep) rsp_pc_d = rsp_pc_q + Xlen'(4);
      if (req_fire) req_pc_d = req_pc_q + Xlen'(4);
      if (push) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
      if (pop) rd_ptr_d = rd_ptr_q + DepthLog2'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc_q   <= ResetPc;
      rsp_pc_q   <= ResetPc;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      inst_mem_q[wr_ptr_q] <= bus.instmem_rdata_i;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni && bus.instmem_rvalid_i) begin
      assert (inflight_q != '0)
        else $error("fetch_unit: response with no request outstanding");
    end
  end
endmodule
